// File: rtl/tlp_f2c_sink.sv
// F2C ring sink: forwards 16-QW chunk writes to data_out, checks metric-mailbox
// write pointers, and answers each good metric with a two-QW read-pointer write TLP.
//
// state  | meaning
// IDLE   | waiting for the first header QW of a packet
// HDR1   | second header QW: dwCount/address decide chunk, metric or drop
// DATA   | 16 payload QWs passed straight through to data_out
// MTR    | two-QW metric payload carrying the FPGA write pointer
// DROP   | swallowing a bad packet up to its eop
// ACK0   | presenting acknowledge header QW
// ACK1   | presenting acknowledge address/value QW
module tlp_f2c_sink #(
    parameter logic [28:0] F2C_QWBASE   = 29'h1BADCAFE,
    parameter logic [28:0] MTR_QWBASE   = 29'h1B00BAB5,
    parameter logic [28:0] RDPTR_QWADDR = 29'h40000 + 29'd3,
    parameter logic [15:0] HOST_ID      = 16'h1CCC
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [63:0] rx_data_in,
    input  logic        rx_valid_in,
    output logic        rx_ready_out,
    input  logic        rx_sop_in,
    input  logic        rx_eop_in,
    output logic [63:0] data_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic [63:0] ack_data_out,
    output logic        ack_valid_out,
    input  logic        ack_ready_in,
    output logic        ack_sop_out,
    output logic        ack_eop_out,
    output logic [3:0]  rd_ptr_out,
    output logic        err_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR1, S_DATA, S_MTR, S_DROP, S_ACK0, S_ACK1
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  dw_cnt_q, dw_cnt_d;
    logic [3:0]  beats_left_q, beats_left_d;
    logic        mtr_second_q, mtr_second_d;
    logic [3:0]  wr_idx_q, wr_idx_d;
    logic [3:0]  fpga_wr_ptr_q, fpga_wr_ptr_d;
    logic [3:0]  rd_ptr_q, rd_ptr_d;
    logic        err_q, err_d;

    logic        rx_fire;
    logic [28:0] chunk_qwaddr;
    logic [28:0] hdr_qwaddr;

    assign rx_fire      = rx_valid_in && rx_ready_out;
    assign chunk_qwaddr = F2C_QWBASE + {21'd0, wr_idx_q, 4'd0};
    assign hdr_qwaddr   = rx_data_in[31:3];
    assign data_out     = rx_data_in;
    assign rd_ptr_out   = rd_ptr_q;
    assign err_out      = err_q;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q       <= S_IDLE;
            dw_cnt_q      <= '0;
            beats_left_q  <= '0;
            mtr_second_q  <= 1'b0;
            wr_idx_q      <= '0;
            fpga_wr_ptr_q <= '0;
            rd_ptr_q      <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            dw_cnt_q      <= dw_cnt_d;
            beats_left_q  <= beats_left_d;
            mtr_second_q  <= mtr_second_d;
            wr_idx_q      <= wr_idx_d;
            fpga_wr_ptr_q <= fpga_wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        dw_cnt_d      = dw_cnt_q;
        beats_left_d  = beats_left_q;
        mtr_second_d  = mtr_second_q;
        wr_idx_d      = wr_idx_q;
        fpga_wr_ptr_d = fpga_wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        err_d         = err_q;
        rx_ready_out  = 1'b0;
        valid_out     = 1'b0;
        ack_valid_out = 1'b0;
        ack_sop_out   = 1'b0;
        ack_eop_out   = 1'b0;
        ack_data_out  = '0;

        // Outputs stay quiet while reset is held, even before the first reset edge.
        if (!reset_in) begin
            case (state_q)
                S_IDLE: begin
                    rx_ready_out = 1'b1;
                    if (rx_fire) begin
                        if (rx_sop_in && !rx_eop_in && rx_data_in[31:24] == 8'h40) begin
                            dw_cnt_d = rx_data_in[9:0];
                            state_d  = S_HDR1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = rx_eop_in ? S_IDLE : S_DROP;
                        end
                    end
                end
                S_HDR1: begin
                    rx_ready_out = 1'b1;
                    if (rx_fire) begin
                        if (rx_eop_in) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end else if (dw_cnt_q == 10'd32 && hdr_qwaddr == chunk_qwaddr) begin
                            beats_left_d = 4'd15;
                            state_d      = S_DATA;
                        end else if (dw_cnt_q == 10'd4 && hdr_qwaddr == MTR_QWBASE) begin
                            mtr_second_d = 1'b0;
                            state_d      = S_MTR;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_DROP;
                        end
                    end
                end
                S_DATA: begin
                    rx_ready_out = ready_in;
                    valid_out    = rx_valid_in;
                    if (rx_fire) begin
                        if (beats_left_q == 4'd0) begin
                            if (rx_eop_in) begin
                                wr_idx_d = wr_idx_q + 4'd1;
                                state_d  = S_IDLE;
                            end else begin
                                err_d   = 1'b1;
                                state_d = S_DROP;
                            end
                        end else begin
                            beats_left_d = beats_left_q - 4'd1;
                            // Early eop already closed the packet, so nothing is left to drop.
                            if (rx_eop_in) begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end
                        end
                    end
                end
                S_MTR: begin
                    rx_ready_out = 1'b1;
                    if (rx_fire) begin
                        if (!mtr_second_q) begin
                            fpga_wr_ptr_d = rx_data_in[3:0];
                            mtr_second_d  = 1'b1;
                            if (rx_eop_in) begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end
                        end else if (!rx_eop_in) begin
                            err_d   = 1'b1;
                            state_d = S_DROP;
                        end else if (fpga_wr_ptr_q == wr_idx_q) begin
                            state_d = S_ACK0;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    rx_ready_out = 1'b1;
                    if (rx_fire && rx_eop_in) begin
                        state_d = S_IDLE;
                    end
                end
                S_ACK0: begin
                    ack_valid_out = 1'b1;
                    ack_sop_out   = 1'b1;
                    ack_data_out  = {HOST_ID, 16'h000F, 8'h40, 14'h0, 10'd1};
                    if (ack_ready_in) begin
                        state_d = S_ACK1;
                    end
                end
                S_ACK1: begin
                    ack_valid_out = 1'b1;
                    ack_eop_out   = 1'b1;
                    ack_data_out  = {28'h0, wr_idx_q, RDPTR_QWADDR, 3'b000};
                    if (ack_ready_in) begin
                        rd_ptr_d = wr_idx_q;
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlp_f2c_sink.sv
// Randomized scoreboard bench for tlp_f2c_sink: packet-level ring model predicts
// payload and acknowledge streams; a negedge monitor pops and compares them.
module tb_tlp_f2c_sink;

    localparam logic [28:0] F2C  = 29'h1BADCAFE;
    localparam logic [28:0] MTR  = 29'h1B00BAB5;
    localparam logic [28:0] RDP  = 29'h40003;
    localparam logic [15:0] HOST = 16'h1CCC;

    logic        clk = 1'b0;
    logic        reset_in;
    logic [63:0] rx_data_in;
    logic        rx_valid_in, rx_ready_out, rx_sop_in, rx_eop_in;
    logic [63:0] data_out;
    logic        valid_out, ready_in;
    logic [63:0] ack_data_out;
    logic        ack_valid_out, ack_ready_in, ack_sop_out, ack_eop_out;
    logic [3:0]  rd_ptr_out;
    logic        err_out;

    tlp_f2c_sink #(
        .F2C_QWBASE  (F2C),
        .MTR_QWBASE  (MTR),
        .RDPTR_QWADDR(RDP),
        .HOST_ID     (HOST)
    ) dut (
        .clk_in       (clk),
        .reset_in     (reset_in),
        .rx_data_in   (rx_data_in),
        .rx_valid_in  (rx_valid_in),
        .rx_ready_out (rx_ready_out),
        .rx_sop_in    (rx_sop_in),
        .rx_eop_in    (rx_eop_in),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .ack_data_out (ack_data_out),
        .ack_valid_out(ack_valid_out),
        .ack_ready_in (ack_ready_in),
        .ack_sop_out  (ack_sop_out),
        .ack_eop_out  (ack_eop_out),
        .rd_ptr_out   (rd_ptr_out),
        .err_out      (err_out)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_data_q[$];
    logic [65:0] exp_ack_q[$];
    logic [63:0] pkt[$];
    logic [65:0] mon_e;
    int          m_wr_idx = 0;
    int          m_rd_ptr = 0;
    logic        m_err    = 1'b0;
    bit          stall_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Random sink backpressure on both output streams.
    initial begin
        ready_in     = 1'b1;
        ack_ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_en) begin
                ready_in     = ($urandom_range(0, 3) != 0);
                ack_ready_in = ($urandom_range(0, 2) != 0);
            end else begin
                ready_in     = 1'b1;
                ack_ready_in = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_in) begin
            if (valid_out)
                check("rx_ready_tracks_ready", {63'd0, rx_ready_out}, {63'd0, ready_in});
            if (valid_out && ready_in) begin
                if (exp_data_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_payload: got %h expected no payload", data_out);
                end else begin
                    check("payload", data_out, exp_data_q.pop_front());
                end
            end
            if (ack_valid_out && ack_ready_in) begin
                if (exp_ack_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got %h expected no ack", ack_data_out);
                end else begin
                    mon_e = exp_ack_q.pop_front();
                    check("ack_data", ack_data_out, mon_e[63:0]);
                    check("ack_sop", {63'd0, ack_sop_out}, {63'd0, mon_e[65]});
                    check("ack_eop", {63'd0, ack_eop_out}, {63'd0, mon_e[64]});
                end
            end
        end
    end

    task automatic send_qw(input logic [63:0] d, input logic sop, input logic eop);
        if (stall_en && $urandom_range(0, 3) == 0) begin
            rx_valid_in = 1'b0;
            @(posedge clk);
            #1;
        end
        rx_data_in  = d;
        rx_sop_in   = sop;
        rx_eop_in   = eop;
        rx_valid_in = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (rx_ready_out) begin
                @(posedge clk);
                #1;
                rx_valid_in = 1'b0;
                rx_sop_in   = 1'b0;
                rx_eop_in   = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        n_fail++;
        $display("FAIL rx_handshake_timeout: got no rx_ready_out expected accept within 400 cycles");
        rx_valid_in = 1'b0;
    endtask

    task automatic send_pkt(input int stop_at);
        for (int i = 0; i < pkt.size(); i++) begin
            if (stop_at >= 0 && i == stop_at) return;
            send_qw(pkt[i], i == 0, i == pkt.size() - 1);
        end
    endtask

    function automatic logic [63:0] hdr0(input logic [9:0] dw);
        return {$urandom(), 8'h40, 14'($urandom()), dw};
    endfunction

    function automatic logic [63:0] hdr1(input logic [28:0] qwaddr);
        return {$urandom(), qwaddr, 3'b000};
    endfunction

    // Builds a chunk write to ring slot k; only the slot the model expects is accepted.
    task automatic build_data(input int k, input bit use_seq, input int n_expect);
        logic [63:0] pay;
        bit          good;
        good = (k == m_wr_idx);
        pkt.delete();
        pkt.push_back(hdr0(10'd32));
        pkt.push_back(hdr1(F2C + 29'(16 * k)));
        for (int i = 0; i < 16; i++) begin
            pay = use_seq ? {32'h5EC00000 + 32'(i), 32'(i)} : {$urandom(), $urandom()};
            pkt.push_back(pay);
            if (good && i < n_expect) exp_data_q.push_back(pay);
        end
    endtask

    task automatic do_data(input int k, input bit use_seq);
        bit good;
        good = (k == m_wr_idx);
        build_data(k, use_seq, 16);
        send_pkt(-1);
        if (good) m_wr_idx = (m_wr_idx + 1) % 16;
        else      m_err = 1'b1;
        check("payload_drained", 64'(exp_data_q.size()), 64'd0);
        check("err_after_data", {63'd0, err_out}, {63'd0, m_err});
    endtask

    task automatic wait_acks();
        for (int n = 0; n < 400 && exp_ack_q.size() != 0; n++) @(negedge clk);
        if (exp_ack_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout: got %0d acks pending expected 0", exp_ack_q.size());
            exp_ack_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_mtr(input int p);
        bit good;
        good = (p == m_wr_idx);
        pkt.delete();
        pkt.push_back(hdr0(10'd4));
        pkt.push_back(hdr1(MTR));
        pkt.push_back({$urandom(), 28'($urandom()), 4'(p)});
        pkt.push_back({$urandom(), $urandom()});
        if (good) begin
            exp_ack_q.push_back({2'b10, HOST, 16'h000F, 8'h40, 14'h0, 10'd1});
            exp_ack_q.push_back({2'b01, 28'h0, 4'(p), RDP, 3'b000});
        end
        send_pkt(-1);
        if (good) begin
            wait_acks();
            m_rd_ptr = p;
        end else begin
            m_err = 1'b1;
        end
        check("rd_ptr", {60'd0, rd_ptr_out}, 64'(m_rd_ptr));
        check("err_after_mtr", {63'd0, err_out}, {63'd0, m_err});
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rx_ready"}, {63'd0, rx_ready_out}, 64'd0);
        check({tag, "_valid"}, {63'd0, valid_out}, 64'd0);
        check({tag, "_ack_valid"}, {63'd0, ack_valid_out}, 64'd0);
        check({tag, "_ack_sop"}, {63'd0, ack_sop_out}, 64'd0);
        check({tag, "_ack_eop"}, {63'd0, ack_eop_out}, 64'd0);
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got no completion expected finish within 500us");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        reset_in    = 1'b1;
        rx_data_in  = hdr0(10'd32);
        rx_valid_in = 1'b1;
        rx_sop_in   = 1'b1;
        rx_eop_in   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_quiet("reset");
        check("reset_rd_ptr", {60'd0, rd_ptr_out}, 64'd0);
        check("reset_err", {63'd0, err_out}, 64'd0);
        rx_valid_in = 1'b0;
        rx_sop_in   = 1'b0;
        rx_eop_in   = 1'b0;
        @(posedge clk);
        #1;
        reset_in = 1'b0;
        @(negedge clk);
        check("idle_rx_ready", {63'd0, rx_ready_out}, 64'd1);
        @(posedge clk);
        #1;
        stall_en = 1'b1;

        do_data(0, 1'b1);
        do_mtr(1);

        for (int i = 1; i < 16; i++) begin
            do_data(m_wr_idx, 1'b0);
            do_mtr(m_wr_idx);
        end
        do_data(0, 1'b0);
        do_mtr(1);

        do_data(2, 1'b0);
        do_data(1, 1'b0);
        do_mtr(2);
        do_mtr(9);
        send_qw({$urandom(), $urandom()}, 1'b0, 1'b1);
        m_err = 1'b1;
        check("err_stray_qw", {63'd0, err_out}, {63'd0, m_err});

        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 3))
                0: do_data(m_wr_idx, 1'b0);
                1: do_data((m_wr_idx + 1 + int'($urandom_range(0, 14))) % 16, 1'b0);
                2: do_mtr(m_wr_idx);
                default: do_mtr(int'($urandom_range(0, 15)));
            endcase
        end

        do_data(m_wr_idx, 1'b0);
        build_data(m_wr_idx, 1'b0, 5);
        send_pkt(7);
        rx_data_in  = pkt[7];
        rx_valid_in = 1'b1;
        reset_in    = 1'b1;
        @(negedge clk);
        check_quiet("midreset");
        @(posedge clk);
        #1;
        reset_in    = 1'b0;
        rx_valid_in = 1'b0;
        m_wr_idx    = 0;
        m_rd_ptr    = 0;
        m_err       = 1'b0;
        check("midreset_payload_count", 64'(exp_data_q.size()), 64'd0);
        check("midreset_rd_ptr", {60'd0, rd_ptr_out}, 64'd0);
        check("midreset_err", {63'd0, err_out}, 64'd0);
        do_data(0, 1'b0);
        do_mtr(1);

        stall_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("final_payload_queue", 64'(exp_data_q.size()), 64'd0);
        check("final_ack_queue", 64'(exp_ack_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
